// File: rtl/ram_arbiter.sv
// Two-master arbiter for a single-port 1024x32 RAM on a shared tri-state data bus.
// Pipeline: grant/accept -> RAM access -> ack; round-robin with an optional bounded lock.
module ram_arbiter #(
    parameter int unsigned MAX_LOCK = 4,
    parameter int unsigned WIN_BITS = 12
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic        m0_lock,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic        m1_lock,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,

    output logic        mem_we,
    output logic [31:0] mem_addr,
    inout  wire  [31:0] mem_data
);

    localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);

    // Arbitration history
    logic             r_last_owner;
    logic             r_last_lock;
    logic [CNT_W-1:0] r_lock_cnt;

    // Access stage
    logic             r_a_valid;
    logic             r_a_owner;
    logic             r_a_we;
    logic             r_a_oor;
    logic [31:0]      r_a_wdata;
    logic [31:0]      r_mem_addr;

    // Ack stage
    logic             r_ack0;
    logic             r_ack1;
    logic             r_err0;
    logic             r_err1;
    logic [31:0]      r_rdata0;
    logic [31:0]      r_rdata1;

    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_accept;
    logic             w_owner;
    logic             w_lock_eff;
    logic             w_other_req;
    logic             w_sel_we;
    logic             w_sel_lock;
    logic [31:0]      w_sel_addr;
    logic [31:0]      w_sel_wdata;
    logic             w_oor;
    logic             w_mem_we;

    assign w_lock_eff = r_last_lock && (r_lock_cnt < CNT_W'(MAX_LOCK));

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (m0_req && m1_req) begin
            // Under lock the previous owner keeps the bus, otherwise the other master takes a turn
            if (w_lock_eff) begin
                w_gnt0 = ~r_last_owner;
                w_gnt1 = r_last_owner;
            end else begin
                w_gnt0 = r_last_owner;
                w_gnt1 = ~r_last_owner;
            end
        end else begin
            w_gnt0 = m0_req;
            w_gnt1 = m1_req;
        end
    end

    assign w_accept    = w_gnt0 | w_gnt1;
    assign w_owner     = w_gnt1;
    assign w_other_req = w_owner ? m0_req : m1_req;

    always_comb begin
        w_sel_we    = m0_we;
        w_sel_lock  = m0_lock;
        w_sel_addr  = m0_addr;
        w_sel_wdata = m0_wdata;
        if (w_owner) begin
            w_sel_we    = m1_we;
            w_sel_lock  = m1_lock;
            w_sel_addr  = m1_addr;
            w_sel_wdata = m1_wdata;
        end
    end

    assign w_oor = |w_sel_addr[31:WIN_BITS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_owner <= 1'b1;
            r_last_lock  <= 1'b0;
            r_lock_cnt   <= '0;
        end else if (w_accept) begin
            r_last_owner <= w_owner;
            r_last_lock  <= w_sel_lock;
            if ((w_owner == r_last_owner) && w_other_req) begin
                if (r_lock_cnt != CNT_W'(MAX_LOCK)) begin
                    r_lock_cnt <= r_lock_cnt + CNT_W'(1);
                end
            end else begin
                r_lock_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a_valid  <= 1'b0;
            r_a_owner  <= 1'b0;
            r_a_we     <= 1'b0;
            r_a_oor    <= 1'b0;
            r_a_wdata  <= '0;
            r_mem_addr <= '0;
        end else begin
            r_a_valid <= w_accept;
            if (w_accept) begin
                r_a_owner  <= w_owner;
                r_a_we     <= w_sel_we;
                r_a_oor    <= w_oor;
                r_a_wdata  <= w_sel_wdata;
                r_mem_addr <= w_sel_addr;
            end
        end
    end

    // Out-of-range accesses never reach the RAM and leave the bus released
    assign w_mem_we = r_a_valid & r_a_we & ~r_a_oor;
    assign mem_we   = w_mem_we;
    assign mem_addr = r_mem_addr;
    assign mem_data = w_mem_we ? r_a_wdata : 32'bz;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_err0   <= 1'b0;
            r_err1   <= 1'b0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            r_ack0 <= r_a_valid & ~r_a_owner;
            r_ack1 <= r_a_valid & r_a_owner;
            r_err0 <= r_a_valid & ~r_a_owner & r_a_oor;
            r_err1 <= r_a_valid & r_a_owner & r_a_oor;
            if (r_a_valid && !r_a_we) begin
                if (r_a_owner) begin
                    r_rdata1 <= r_a_oor ? 32'h0 : mem_data;
                end else begin
                    r_rdata0 <= r_a_oor ? 32'h0 : mem_data;
                end
            end
        end
    end

    assign m0_gnt   = w_gnt0;
    assign m1_gnt   = w_gnt1;
    assign m0_ack   = r_ack0;
    assign m1_ack   = r_ack1;
    assign m0_err   = r_err0;
    assign m1_err   = r_err1;
    assign m0_rdata = r_rdata0;
    assign m1_rdata = r_rdata1;

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized and directed bench for ram_arbiter against a transaction-level model
// of the arbitration rules and of the RAM contents.
module tb_ram_arbiter;

    localparam int unsigned MAX_LOCK = 4;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_we, m0_lock, m0_gnt, m0_ack, m0_err;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_lock, m1_gnt, m1_ack, m1_err;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        mem_we;
    logic [31:0] mem_addr;
    wire  [31:0] mem_data;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic        req;
        logic        we;
        logic        lock;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic        g0, g1, a0, a1, e0, e1, we, x;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd0;
        logic [31:0] rd1;
    } obs_t;

    typedef struct packed {
        logic        valid, owner, we, oor;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
    } acc_t;

    ram_arbiter #(.MAX_LOCK(MAX_LOCK), .WIN_BITS(12)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_err(m0_err),
        .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_err(m1_err),
        .m1_rdata(m1_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data)
    );

    // Behavioural single-port RAM: drives the bus whenever it is not being written
    logic [31:0] ram [1024] = '{default: '0};
    always @(posedge clk) if (mem_we) ram[mem_addr[11:2]] <= mem_data;
    assign mem_data = mem_we ? 32'bz : ram[mem_addr[11:2]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: arbitration history, in-flight accesses, memory image
    logic        m_last_owner, m_last_lock;
    int          m_streak;
    acc_t        s1, s2;
    logic [31:0] m_rd0, m_rd1, m_addr;
    logic [31:0] mref [1024] = '{default: '0};
    cmd_t        idle_c = '0;

    task automatic model_reset();
        m_last_owner = 1'b1;
        m_last_lock  = 1'b0;
        m_streak     = 0;
        s1 = '0;
        s2 = '0;
        m_rd0 = '0;
        m_rd1 = '0;
        m_addr = '0;
    endtask

    task automatic sample(output obs_t o);
        o.g0 = m0_gnt;  o.g1 = m1_gnt;
        o.a0 = m0_ack;  o.a1 = m1_ack;
        o.e0 = m0_err;  o.e1 = m1_err;
        o.we = mem_we;
        o.x = $isunknown(mem_data);
        o.addr = mem_addr;
        o.wd = mem_we ? mem_data : 32'h0;
        o.rd0 = m0_rdata;
        o.rd1 = m1_rdata;
    endtask

    function automatic cmd_t mk(input logic we, input logic lock, input logic [31:0] addr,
                                input logic [31:0] wdata);
        cmd_t c;
        c.req = 1'b1; c.we = we; c.lock = lock; c.addr = addr; c.wdata = wdata;
        return c;
    endfunction

    // One clock cycle: drive commands, sample DUT and build the model's expectation,
    // then advance the model over the coming edge.
    task automatic run_cycle(input cmd_t c0, input cmd_t c1, output obs_t o, output obs_t e);
        logic win;
        logic locked;
        cmd_t c;
        acc_t na;
        @(negedge clk);
        m0_req = c0.req; m0_we = c0.we; m0_lock = c0.lock; m0_addr = c0.addr; m0_wdata = c0.wdata;
        m1_req = c1.req; m1_we = c1.we; m1_lock = c1.lock; m1_addr = c1.addr; m1_wdata = c1.wdata;
        #2;
        e = '0;
        if (c0.req && c1.req) begin
            locked = m_last_lock && (m_streak < MAX_LOCK);
            win = locked ? m_last_owner : ~m_last_owner;
            e.g0 = ~win;
            e.g1 = win;
        end else begin
            e.g0 = c0.req;
            e.g1 = c1.req;
        end
        if (s2.valid && !s2.we) begin
            if (s2.owner) m_rd1 = s2.rd;
            else m_rd0 = s2.rd;
        end
        if (s1.valid) m_addr = s1.addr;
        e.a0 = s2.valid && !s2.owner;
        e.a1 = s2.valid && s2.owner;
        e.e0 = e.a0 && s2.oor;
        e.e1 = e.a1 && s2.oor;
        e.we = s1.valid && s1.we && !s1.oor;
        e.addr = m_addr;
        e.wd = e.we ? s1.wdata : 32'h0;
        e.rd0 = m_rd0;
        e.rd1 = m_rd1;
        sample(o);
        // Accesses are serialized, so applying each one in order at its RAM cycle is exact
        if (s1.valid && !s1.oor) begin
            if (s1.we) mref[s1.addr[11:2]] = s1.wdata;
            else s1.rd = mref[s1.addr[11:2]];
        end else begin
            s1.rd = 32'h0;
        end
        s2 = s1;
        na = '0;
        if (e.g0 || e.g1) begin
            win = e.g1;
            c = win ? c1 : c0;
            na.valid = 1'b1; na.owner = win; na.we = c.we;
            na.addr = c.addr; na.wdata = c.wdata; na.oor = |c.addr[31:12];
            if (win == m_last_owner && (win ? c0.req : c1.req)) m_streak++;
            else m_streak = 0;
            m_last_owner = win;
            m_last_lock = c.lock;
        end
        s1 = na;
    endtask

    task automatic reset_dut();
        obs_t o;
        @(negedge clk);
        rst = 1'b0;
        m0_req = 1'b0; m1_req = 1'b0;
        #2;
        sample(o);
        n_tests++;
        if (o.g0 !== 1'b0 || o.g1 !== 1'b0 || o.a0 !== 1'b0 || o.a1 !== 1'b0 || o.we !== 1'b0
            || o.addr !== 32'h0 || o.rd0 !== 32'h0 || o.rd1 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: got %h required all-zero outputs", o);
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        obs_t o;
        #3;
        sample(o);
        n_tests++;
        if (o.g0 !== 1'b0 || o.g1 !== 1'b0 || o.a0 !== 1'b0 || o.a1 !== 1'b0 || o.e0 !== 1'b0
            || o.e1 !== 1'b0 || o.we !== 1'b0 || o.addr !== 32'h0 || o.rd0 !== 32'h0
            || o.rd1 !== 32'h0) begin
            n_fail++;
            $display("FAIL power_on_reset: got %h required all-zero outputs", o);
        end
        reset_dut();
    endtask

    task automatic test_single_wr_rd();
        obs_t o, e;
        cmd_t seq [6];
        seq[0] = mk(1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
        seq[1] = idle_c; seq[2] = idle_c;
        seq[3] = mk(1'b0, 1'b0, 32'h10, 32'h0);
        seq[4] = idle_c; seq[5] = idle_c;
        for (int i = 0; i < 6; i++) begin
            run_cycle(seq[i], idle_c, o, e);
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL single_wr_rd cycle %0d: got %h required %h", i, o, e);
            end
            if (i == 1) begin
                n_tests++;
                if (o.we !== 1'b1 || o.addr !== 32'h10 || o.wd !== 32'hDEADBEEF) begin
                    n_fail++;
                    $display("FAIL single_write_bus: we=%b addr=%h data=%h required 1/10/deadbeef",
                             o.we, o.addr, o.wd);
                end
            end
            if (i == 5) begin
                n_tests++;
                if (o.a0 !== 1'b1 || o.e0 !== 1'b0 || o.rd0 !== 32'hDEADBEEF) begin
                    n_fail++;
                    $display("FAIL single_read_ack: ack=%b err=%b rdata=%h required 1/0/deadbeef",
                             o.a0, o.e0, o.rd0);
                end
            end
        end
    endtask

    task automatic test_contention();
        obs_t o, e;
        reset_dut();
        for (int i = 0; i < 10; i++) begin
            run_cycle(mk(1'b0, 1'b0, 32'(i * 4), 32'h0), mk(1'b0, 1'b0, 32'(i * 8), 32'h0), o, e);
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL contention cycle %0d: got %h required %h", i, o, e);
            end
            n_tests++;
            if (o.g0 !== ((i % 2) == 0) || o.g1 !== ((i % 2) == 1)) begin
                n_fail++;
                $display("FAIL contention_alternate cycle %0d: gnt0=%b gnt1=%b required %b/%b",
                         i, o.g0, o.g1, (i % 2) == 0, (i % 2) == 1);
            end
        end
    endtask

    task automatic test_lock_bound();
        obs_t o, e;
        logic pat [8];
        pat = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        reset_dut();
        for (int i = 0; i < 8; i++) begin
            run_cycle(mk(1'b0, 1'b0, 32'h40, 32'h0), mk(1'b0, 1'b1, 32'(i * 4), 32'h0), o, e);
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL lock_bound cycle %0d: got %h required %h", i, o, e);
            end
            n_tests++;
            if (o.g1 !== pat[i] || o.g0 !== ~pat[i]) begin
                n_fail++;
                $display("FAIL lock_sequence cycle %0d: gnt1=%b required %b", i, o.g1, pat[i]);
            end
        end
    endtask

    task automatic test_out_of_range();
        obs_t o, e;
        cmd_t seq [9];
        seq[0] = mk(1'b1, 1'b0, 32'h0, 32'hCAFE0000);
        seq[1] = idle_c; seq[2] = idle_c;
        seq[3] = mk(1'b1, 1'b0, 32'h0000_1000, 32'h1234);
        seq[4] = idle_c; seq[5] = idle_c;
        seq[6] = mk(1'b0, 1'b0, 32'h0, 32'h0);
        seq[7] = idle_c; seq[8] = idle_c;
        for (int i = 0; i < 9; i++) begin
            run_cycle(idle_c, seq[i], o, e);
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL out_of_range cycle %0d: got %h required %h", i, o, e);
            end
            if (i == 4) begin
                n_tests++;
                if (o.we !== 1'b0 || o.x !== 1'b0) begin
                    n_fail++;
                    $display("FAIL oor_no_write: mem_we=%b x=%b required 0/0", o.we, o.x);
                end
            end
            if (i == 5) begin
                n_tests++;
                if (o.a1 !== 1'b1 || o.e1 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL oor_err: ack=%b err=%b required 1/1", o.a1, o.e1);
                end
            end
            if (i == 8) begin
                n_tests++;
                if (o.a1 !== 1'b1 || o.e1 !== 1'b0 || o.rd1 !== 32'hCAFE0000) begin
                    n_fail++;
                    $display("FAIL oor_preserve: ack=%b err=%b rdata=%h required 1/0/cafe0000",
                             o.a1, o.e1, o.rd1);
                end
            end
        end
    endtask

    task automatic test_back_to_back_raw();
        obs_t o, e;
        cmd_t seq [5];
        seq[0] = mk(1'b1, 1'b0, 32'h20, 32'h55);
        seq[1] = mk(1'b0, 1'b0, 32'h20, 32'h0);
        seq[2] = idle_c; seq[3] = idle_c; seq[4] = idle_c;
        for (int i = 0; i < 5; i++) begin
            run_cycle(seq[i], idle_c, o, e);
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL raw cycle %0d: got %h required %h", i, o, e);
            end
            if (i == 3) begin
                n_tests++;
                if (o.a0 !== 1'b1 || o.rd0 !== 32'h55) begin
                    n_fail++;
                    $display("FAIL raw_data: ack=%b rdata=%h required 1/00000055", o.a0, o.rd0);
                end
            end
        end
    endtask

    task automatic test_reset_mid_access();
        obs_t o, e;
        run_cycle(mk(1'b1, 1'b0, 32'h30, 32'hA5A5A5A5), idle_c, o, e);
        @(negedge clk);
        m0_req = 1'b0; m1_req = 1'b0;
        #2;
        n_tests++;
        if (mem_we !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_pre_we: mem_we=%b required 1", mem_we);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (mem_we !== 1'b0 || m0_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_async: mem_we=%b ack=%b required 0/0", mem_we, m0_ack);
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            run_cycle(idle_c, idle_c, o, e);
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL midreset_idle cycle %0d: got %h required %h", i, o, e);
            end
        end
        for (int i = 0; i < 4; i++) begin
            run_cycle(mk(1'b0, 1'b0, 32'h30, 32'h0), mk(1'b0, 1'b0, 32'h30, 32'h0), o, e);
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL midreset_after cycle %0d: got %h required %h", i, o, e);
            end
            if (i == 0) begin
                n_tests++;
                if (o.g0 !== 1'b1 || o.g1 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL midreset_first_grant: gnt0=%b gnt1=%b required 1/0", o.g0, o.g1);
                end
            end
            if (i == 2) begin
                n_tests++;
                if (o.rd0 !== 32'h0) begin
                    n_fail++;
                    $display("FAIL midreset_dropped_write: rdata=%h required 0", o.rd0);
                end
            end
        end
    endtask

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.req = 1'b1;
        c.we = 1'($urandom_range(0, 1));
        c.lock = ($urandom_range(0, 3) == 0);
        c.wdata = $urandom;
        if ($urandom_range(0, 7) == 0) c.addr = (32'h1 << $urandom_range(12, 31)) | 32'($urandom_range(0, 255));
        else c.addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
        return c;
    endfunction

    task automatic test_random();
        obs_t o, e;
        cmd_t p0, p1;
        p0 = '0;
        p1 = '0;
        for (int i = 0; i < 400; i++) begin
            if (!p0.req && $urandom_range(0, 9) < 7) p0 = rand_cmd();
            if (!p1.req && $urandom_range(0, 9) < 7) p1 = rand_cmd();
            run_cycle(p0, p1, o, e);
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL random cycle %0d: got %h required %h", i, o, e);
            end
            if (e.g0) p0 = '0;
            if (e.g1) p1 = '0;
        end
        for (int i = 0; i < 3; i++) begin
            run_cycle(idle_c, idle_c, o, e);
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL random_drain cycle %0d: got %h required %h", i, o, e);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        m0_req = 1'b0; m0_we = 1'b0; m0_lock = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_lock = 1'b0; m1_addr = '0; m1_wdata = '0;
        model_reset();
        test_reset();
        test_single_wr_rd();
        test_contention();
        test_lock_bound();
        test_out_of_range();
        test_back_to_back_raw();
        test_reset_mid_access();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-port arbiter sharing the single-port 1024x32 word RAM (4 KiB window, shared tri-state mem_data bus) between master 0 (core load/store) and master 1 (DMA/debug loader).
- Pipelined request/grant/ack protocol: one RAM access per cycle, round-robin fairness, optional bounded bus lock for bursts.
- Drives mem_data only during writes, so it never contends with the RAM's read drive.

Parameters:
- MAX_LOCK, 4, maximum consecutive grants to a locking master while the other master is requesting.
- WIN_BITS, 12, address bits decoded by the RAM; any set bit above WIN_BITS-1 is out of range.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- m0_req  in  1  master 0 request; held with its command until granted.
- m0_we  in  1  master 0 write (1) / read (0).
- m0_lock  in  1  master 0 requests to keep ownership next cycle.
- m0_addr  in  32  master 0 byte address.
- m0_wdata  in  32  master 0 write data.
- m0_gnt  out  1  combinational grant; the request is accepted at the edge where req&gnt.
- m0_ack  out  1  one-cycle completion pulse.
- m0_err  out  1  qualifies ack: address out of range.
- m0_rdata  out  32  read data, valid with ack on reads.
- m1_*  same set as m0_*, for master 1.
- mem_we  out  1  RAM write enable.
- mem_addr  out  32  RAM byte address.
- mem_data  inout  32  driven with write data when mem_we=1, otherwise high-Z.

Behaviour:
- Reset (rst=0, async): mem_we=0, mem_addr=0, mem_data=Z, all gnt/ack/err=0, all rdata=0, last_owner=1 (master 0 wins first), lock_cnt=0, pipeline stage invalid.
- Grant (combinational, cycle N):
  - If only one req is high, that master is granted.
  - If both are high, the master != last_owner is granted, unless lock is in effect.
  - Lock is in effect when last_owner asserted lock on its accepted request and lock_cnt < MAX_LOCK.
  - At most one gnt is high per cycle. gnt is never high without the matching req.
- Accept (edge ending N):
  - Register owner, we, addr, wdata and the range flag into the access stage.
  - last_owner <= owner.
  - lock_cnt increments when the same master is regranted while the other requests; otherwise it clears.
- Access (cycle N+1), in-range:
  - mem_addr = registered addr.
  - mem_we = registered we.
  - mem_data driven with wdata only if we=1.
  - The RAM writes at the end of N+1. For a read, mem_data is sampled at the end of N+1.
- Access (cycle N+1), out-of-range (addr[31:WIN_BITS] != 0): mem_we=0, mem_data=Z, no RAM write.
- Ack (cycle N+2):
  - The owner's ack=1 for one cycle.
  - Reads: rdata = sampled data, or 0 if err.
  - err=1 iff out of range.
  - rdata holds its value until the next read ack to that master.
- Idle access cycle: mem_we=0 and mem_addr holds its last value. Read data is ignored.
- Throughput: back-to-back accepts in consecutive cycles, pipelined with no bubbles. Latency is 2 cycles from accept to ack.
- Read-after-write: a read accepted the cycle after a write to the same word returns the new data.
- Simultaneous events:
  - Both masters requesting with no lock: grants alternate every cycle.
  - Lock overrun: after MAX_LOCK consecutive locked regrants with the other master waiting, the other master is granted.
- Reset mid-operation: in-flight access is dropped, no ack is issued, mem_we deasserts immediately (async).

Test Plan:
- Single write then read: m0 writes 0xDEADBEEF to 0x10, then reads 0x10 -> gnt in the request cycle, mem_we=1 one cycle later, ack at +2; read ack returns rdata=0xDEADBEEF, err=0.
- Contention: m0 and m1 request reads every cycle, no lock -> grants alternate m0,m1,m0,m1 from reset; each ack arrives 2 cycles after its grant; no cycle has both gnt high.
- Lock bound: m1 locks continuously while m0 requests, MAX_LOCK=4 -> m1 is granted 5 consecutive times (initial plus 4 regrants), then m0 is granted.
- Out of range: m1 writes 0x1234 to address 0x0000_1000 -> mem_we stays 0, ack with err=1; a later read of address 0 still returns its previous value.
- Read-after-write pipelined: m0 writes 0x55 to 0x20 in cycle N and reads 0x20 in cycle N+1 -> read ack at N+3 with rdata=0x55. mem_data is Z in every non-write cycle (bench checks no X from contention).
- Reset mid-access: assert rst=0 the cycle after a write grant -> mem_we drops immediately, no ack; after release, m0 wins the first contended grant.
